// File: rtl/cacheline_burst_adapter_if.sv
// Bus bundle for the cache-line to memory-burst adapter.
// Arbiter-side line request signals plus memory-side burst signals.
interface cacheline_burst_adapter_if #(
  parameter int BURST_WIDTH = 64,
  parameter int BURSTS      = 4
);
  localparam int LINE_WIDTH = BURST_WIDTH * BURSTS;

  logic [31:0]            address_i;
  logic                   read_i;
  logic                   write_i;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic                   resp_o;

  logic [31:0]            address_o;
  logic                   read_o;
  logic                   write_o;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic                   resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i,
    output line_o, resp_o,
    output address_o, read_o, write_o, burst_o,
    input  burst_i, resp_i
  );

  modport master (
    output address_i, read_i, write_i, line_i,
    input  line_o, resp_o,
    input  address_o, read_o, write_o, burst_o,
    output burst_i, resp_i
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Cache-line to memory-burst adapter.
// One line read/write from the arbiter becomes a BURSTS-beat memory burst.
module cacheline_burst_adapter #(
  parameter int BURST_WIDTH = 64,
  parameter int BURSTS      = 4
) (
  input logic clk,
  input logic rst,
  cacheline_burst_adapter_if.slave bus
);
  localparam int LINE_WIDTH = BURST_WIDTH * BURSTS;
  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam int CW = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURSTS - 1);
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_BYTES) - 32'd1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [31:0]            r_addr;
  logic [LINE_WIDTH-1:0]  r_wline;
  logic [LINE_WIDTH-1:0]  r_rline;
  logic [BURST_WIDTH-1:0] w_wbeat;
  logic                   w_last;

  assign w_last = (r_cnt == LAST);

  // FSM, beat counter, latched address and write line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wline <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.read_i) begin
            r_state <= RD;
            r_addr  <= bus.address_i & ALIGN_MASK;
          end else if (bus.write_i) begin
            r_state <= WR;
            r_addr  <= bus.address_i & ALIGN_MASK;
            r_wline <= bus.line_i;
          end
        end
        RD, WR: begin
          if (bus.resp_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= DONE;
              r_cnt   <= '0;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read beats land in their line slice; only read bursts touch line_o
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rline <= '0;
    end else if (r_state == RD && bus.resp_i) begin
      r_rline[int'(r_cnt)*BURST_WIDTH +: BURST_WIDTH] <= bus.burst_i;
    end
  end

  // Current write beat selected straight from the counter
  always_comb begin
    w_wbeat = '0;
    if (r_state == WR) begin
      w_wbeat = r_wline[int'(r_cnt)*BURST_WIDTH +: BURST_WIDTH];
    end
  end

  assign bus.read_o    = (r_state == RD);
  assign bus.write_o   = (r_state == WR);
  assign bus.resp_o    = (r_state == DONE);
  assign bus.address_o = r_addr;
  assign bus.burst_o   = w_wbeat;
  assign bus.line_o    = r_rline;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Self-checking bench for cacheline_burst_adapter.
// Bench plays arbiter and memory; model tracks line/address.
module tb_cacheline_burst_adapter;
  localparam int BW = 64;
  localparam int NB = 4;
  localparam int LW = BW * NB;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [LW-1:0] mdl_line;

  cacheline_burst_adapter_if #(.BURST_WIDTH(BW), .BURSTS(NB)) bus ();

  cacheline_burst_adapter #(.BURST_WIDTH(BW), .BURSTS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.address_i = '0;
    bus.read_i    = 0;
    bus.write_i   = 0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 0;
  endtask

  // One line transaction; gap 0 = back-to-back beats, 1 = alternate, 2 = random
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [LW-1:0] line, input int gap,
                         input bit pattern, input bit drop);
    logic [LW-1:0] tmp;
    logic [31:0]   exp_addr;
    logic [BW-1:0] beat;
    bit            isrd;
    bit            give;
    int            beats;
    int            cyc;
    isrd     = rd;
    exp_addr = addr & ~32'd31;
    tmp      = mdl_line;
    @(negedge clk);
    bus.address_i = addr;
    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.line_i    = line;
    bus.resp_i    = 0;
    @(negedge clk);
    beats = 0;
    cyc   = 0;
    while (beats < NB && cyc < 64) begin
      n_checks++;
      if (bus.read_o !== isrd || bus.write_o !== !isrd || bus.resp_o !== 0) begin
        n_fail++;
        $display("FAIL busy_ctrl: rd=%b wr=%b resp=%b want rd=%b wr=%b resp=0",
                 bus.read_o, bus.write_o, bus.resp_o, isrd, !isrd);
      end
      n_checks++;
      if (bus.address_o !== exp_addr) begin
        n_fail++;
        $display("FAIL addr_busy: got %h want %h", bus.address_o, exp_addr);
      end
      if (!isrd) begin
        n_checks++;
        if (bus.burst_o !== line[beats*BW +: BW]) begin
          n_fail++;
          $display("FAIL wr_beat%0d: got %h want %h", beats, bus.burst_o,
                   line[beats*BW +: BW]);
        end
      end
      if (gap == 0) give = 1;
      else if (gap == 1) give = cyc[0];
      else give = ($urandom_range(0, 2) != 0);
      if (pattern) beat = 64'h1111_1111_1111_1111 * 64'(beats + 1);
      else beat = {$urandom, $urandom};
      bus.resp_i  = give;
      bus.burst_i = beat;
      if (give) begin
        if (isrd) tmp[beats*BW +: BW] = beat;
        beats++;
      end
      if (drop && cyc == 0) begin
        bus.read_i  = 0;
        bus.write_i = 0;
      end
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (beats < NB) begin
      n_fail++;
      $display("FAIL burst_timeout: beats %0d want %0d", beats, NB);
    end
    if (isrd) mdl_line = tmp;
    bus.resp_i  = 1;
    bus.burst_i = {$urandom, $urandom};
    n_checks++;
    if (bus.resp_o !== 1 || bus.read_o !== 0 || bus.write_o !== 0) begin
      n_fail++;
      $display("FAIL done_ctrl: resp=%b rd=%b wr=%b want 1 0 0",
               bus.resp_o, bus.read_o, bus.write_o);
    end
    n_checks++;
    if (bus.line_o !== mdl_line) begin
      n_fail++;
      $display("FAIL line_o: got %h want %h", bus.line_o, mdl_line);
    end
    n_checks++;
    if (bus.address_o !== exp_addr) begin
      n_fail++;
      $display("FAIL addr_done: got %h want %h", bus.address_o, exp_addr);
    end
    bus.read_i  = 0;
    bus.write_i = 0;
    @(negedge clk);
    bus.resp_i = 0;
    n_checks++;
    if (bus.resp_o !== 0 || bus.read_o !== 0 || bus.write_o !== 0) begin
      n_fail++;
      $display("FAIL after_done: resp=%b rd=%b wr=%b want 0 0 0",
               bus.resp_o, bus.read_o, bus.write_o);
    end
    n_checks++;
    if (bus.line_o !== mdl_line) begin
      n_fail++;
      $display("FAIL line_hold: got %h want %h", bus.line_o, mdl_line);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    mdl_line = '0;
    n_checks++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000 ||
        bus.address_o !== 32'd0 || bus.burst_o !== '0 || bus.line_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd=%b wr=%b resp=%b addr=%h burst=%h line=%h",
               bus.read_o, bus.write_o, bus.resp_o, bus.address_o, bus.burst_o, bus.line_o);
    end
  endtask

  task automatic test_read_basic();
    run_txn(1, 0, 32'h0000_1234, '0, 0, 1, 0);
    n_checks++;
    if (bus.line_o !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
      n_fail++;
      $display("FAIL read_pattern: got %h", bus.line_o);
    end
    n_checks++;
    if (bus.address_o !== 32'h0000_1220) begin
      n_fail++;
      $display("FAIL read_addr: got %h want 00001220", bus.address_o);
    end
  endtask

  task automatic test_write_gaps();
    logic [LW-1:0] l;
    l = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
         64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    run_txn(0, 1, 32'h8000_003F, l, 1, 0, 0);
    n_checks++;
    if (bus.address_o !== 32'h8000_0020) begin
      n_fail++;
      $display("FAIL write_addr: got %h want 80000020", bus.address_o);
    end
  endtask

  task automatic test_both_high();
    run_txn(1, 1, {$urandom}, {8{$urandom}}, 2, 0, 0);
  endtask

  task automatic test_spurious_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.resp_i  = 1;
      bus.burst_i = {$urandom, $urandom};
      n_checks++;
      if (bus.resp_o !== 0 || bus.read_o !== 0 || bus.write_o !== 0 ||
          bus.line_o !== mdl_line) begin
        n_fail++;
        $display("FAIL idle_spurious: resp=%b rd=%b wr=%b line=%h want 0 0 0 %h",
                 bus.resp_o, bus.read_o, bus.write_o, bus.line_o, mdl_line);
      end
    end
    @(negedge clk);
    bus.resp_i = 0;
    run_txn(1, 0, {$urandom}, '0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    bus.address_i = 32'h0000_4000;
    bus.read_i    = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bus.resp_i  = 1;
      bus.burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.resp_i = 0;
    bus.read_i = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    mdl_line = '0;
    n_checks++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000 ||
        bus.address_o !== 32'd0 || bus.burst_o !== '0 || bus.line_o !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rd=%b wr=%b resp=%b addr=%h line=%h",
               bus.read_o, bus.write_o, bus.resp_o, bus.address_o, bus.line_o);
    end
    @(negedge clk);
    n_checks++;
    if (bus.resp_o !== 0 || bus.read_o !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: resp=%b rd=%b want 0 0", bus.resp_o, bus.read_o);
    end
    run_txn(1, 0, 32'h0000_4010, '0, 2, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_txn(1, 0, {$urandom}, '0, 0, 0, 0);
    run_txn(0, 1, {$urandom}, {8{$urandom}}, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit r;
      bit w;
      r = $urandom_range(0, 1);
      w = !r || ($urandom_range(0, 1) == 1);
      run_txn(r, w, {$urandom}, {8{$urandom}}, $urandom_range(0, 2), 0,
              $urandom_range(0, 1));
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_read_basic();
    test_write_gaps();
    test_both_high();
    test_spurious_idle();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
